// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory mailbox responder.
//  status_t        run verdict encoding
//  DEF_*           default mailbox / scratch addresses and pass value
//  addr_in_range() true when a byte address is word aligned and inside the array
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } status_t;

  localparam int unsigned WORD_W           = 32;
  localparam int unsigned CNT_W            = 16;
  localparam int unsigned DEF_MBOX_ADDR    = 100;
  localparam int unsigned DEF_SCRATCH_ADDR = 96;
  localparam int unsigned DEF_PASS_VALUE   = 7;

  // Aligned and below 4*depth bytes.
  function automatic logic addr_in_range(input logic [31:0] adr, input int unsigned depth);
    return (adr < 32'(depth * 4)) && (adr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 storage: synchronous write, asynchronous read.
//  clk    in   clock
//  we     in   write enable for this edge
//  addr   in   word index (shared by read and write)
//  wdata  in   store data
//  rdata  out  combinational read of mem[addr]
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH     = 64,
  parameter string       INIT_FILE = "",
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_mailbox.sv
// Data-memory responder for the core's data port with a sticky run verdict.
//  clk, reset  clock, synchronous active-high reset
//  DataAdr     byte address from the core
//  WriteData   store data
//  MemWrite    store strobe
//  ReadData    combinational load data (0 when address is bad)
//  done        verdict reached
//  status      ST_RUN / ST_PASS / ST_FAIL / ST_TIMEOUT
//  wr_count    accepted stores since reset, saturating
//  cycle_cnt   cycles in ST_RUN since reset release, saturating
//  addr_err    sticky bad-store flag
module dmem_mailbox
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH          = 64,
  parameter int unsigned MBOX_ADDR      = DEF_MBOX_ADDR,
  parameter int unsigned SCRATCH_ADDR   = DEF_SCRATCH_ADDR,
  parameter int unsigned PASS_VALUE     = DEF_PASS_VALUE,
  parameter bit          STRICT         = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 40,
  parameter string       INIT_FILE      = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       DataAdr,
  input  logic [31:0]       WriteData,
  input  logic              MemWrite,
  output logic [31:0]       ReadData,
  output logic              done,
  output status_t           status,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic              addr_err
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic              in_range;
  logic              wr_ok;
  logic              is_mbox;
  logic              is_scratch;
  logic [31:0]       rdata;
  status_t           status_next;

  assign in_range   = addr_in_range(DataAdr, DEPTH);
  assign wr_ok      = MemWrite && in_range;
  assign is_mbox    = (DataAdr == 32'(MBOX_ADDR));
  assign is_scratch = (DataAdr == 32'(SCRATCH_ADDR));

  dmem_array #(
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk   (clk),
    .we    (wr_ok),
    .addr  (DataAdr[AW+1:2]),
    .wdata (WriteData),
    .rdata (rdata)
  );

  assign ReadData = in_range ? rdata : 32'h0;

  // Verdict decision; store events take priority over the watchdog.
  always_comb begin
    status_next = status;
    if (status == ST_RUN) begin
      if (MemWrite && is_mbox) begin
        status_next = (WriteData == 32'(PASS_VALUE)) ? ST_PASS : ST_FAIL;
      end else if (STRICT && MemWrite && !is_scratch) begin
        status_next = ST_FAIL;
      end else if ((TIMEOUT_CYCLES != 0) && (cycle_cnt == TO_LAST)) begin
        status_next = ST_TIMEOUT;
      end
    end
  end

  // Verdict register and counters; cycle_cnt freezes on the verdict edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      status    <= ST_RUN;
      done      <= 1'b0;
      wr_count  <= '0;
      cycle_cnt <= '0;
      addr_err  <= 1'b0;
    end else begin
      status <= status_next;
      done   <= (status_next != ST_RUN);
      if ((status_next == ST_RUN) && (cycle_cnt != CNT_MAX)) cycle_cnt <= cycle_cnt + 1'b1;
      if (wr_ok && (wr_count != CNT_MAX)) wr_count <= wr_count + 1'b1;
      if (MemWrite && !in_range) addr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_mailbox.sv
// Bench for dmem_mailbox: a STRICT and a non-STRICT instance share stimulus and
// are compared against a behavioural model, a vector table and hand sequences.
module tb_dmem_mailbox;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic        MemWrite = 1'b0;

  logic [31:0] rd_s, rd_n;
  logic        done_s, done_n;
  status_t     st_s, st_n;
  logic [15:0] wrc_s, wrc_n, cyc_s, cyc_n;
  logic        err_s, err_n;

  always #5 clk = ~clk;

  dmem_mailbox u_dut (
    .clk(clk), .reset(reset), .DataAdr(DataAdr), .WriteData(WriteData),
    .MemWrite(MemWrite), .ReadData(rd_s), .done(done_s), .status(st_s),
    .wr_count(wrc_s), .cycle_cnt(cyc_s), .addr_err(err_s)
  );

  dmem_mailbox #(.STRICT(1'b0)) u_ns (
    .clk(clk), .reset(reset), .DataAdr(DataAdr), .WriteData(WriteData),
    .MemWrite(MemWrite), .ReadData(rd_n), .done(done_n), .status(st_n),
    .wr_count(wrc_n), .cycle_cnt(cyc_n), .addr_err(err_n)
  );

  // Reference model state
  typedef struct {
    status_t     st;
    int unsigned cyc;
    int unsigned wr;
    bit          err;
  } mdl_t;

  mdl_t        ms, mn;
  logic [31:0] mem_m [int];
  int          vecs = 0;
  int          errs = 0;
  int          step_no = 0;

  function automatic bit good_adr(input logic [31:0] a);
    return (a < 32'd256) && (a % 4 == 0);
  endfunction

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.st = ST_RUN; m.cyc = 0; m.wr = 0; m.err = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mdl_next(input mdl_t m, input bit strict, input bit w,
                                    input logic [31:0] a, input logic [31:0] d);
    mdl_t n = m;
    bit   illegal = w && strict && (a != 32'd100) && (a != 32'd96);
    if (m.st == ST_RUN) begin
      if (w && a == 32'd100)   n.st = (d == 32'd7) ? ST_PASS : ST_FAIL;
      else if (illegal)        n.st = ST_FAIL;
      else if (m.cyc == 39)    n.st = ST_TIMEOUT;
    end
    if (n.st == ST_RUN && m.cyc < 65535) n.cyc = m.cyc + 1;
    if (w && good_adr(a) && m.wr < 65535) n.wr = m.wr + 1;
    if (w && !good_adr(a)) n.err = 1'b1;
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, step_no, act, exp);
    end
  endtask

  // One clock: drive, advance model on the edge, check on the falling edge.
  task automatic step(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    reset = r; MemWrite = w; DataAdr = a; WriteData = d;
    @(posedge clk);
    if (r) begin
      ms = mdl_reset(); mn = mdl_reset();
    end else begin
      ms = mdl_next(ms, 1'b1, w, a, d);
      mn = mdl_next(mn, 1'b0, w, a, d);
    end
    if (w && good_adr(a)) mem_m[int'(a >> 2)] = d;
    @(negedge clk);
    step_no++;
    chk("status_strict", 32'(st_s), 32'(ms.st));
    chk("done_strict", 32'(done_s), 32'(ms.st != ST_RUN));
    chk("wr_count", 32'(wrc_s), ms.wr);
    chk("cycle_cnt", 32'(cyc_s), ms.cyc);
    chk("addr_err", 32'(err_s), 32'(ms.err));
    chk("status_loose", 32'(st_n), 32'(mn.st));
    chk("cycle_cnt_loose", 32'(cyc_n), mn.cyc);
    chk("addr_err_loose", 32'(err_n), 32'(mn.err));
    if (!good_adr(a)) begin
      chk("rdata_bad", rd_s, 32'h0);
      chk("rdata_bad_loose", rd_n, 32'h0);
    end else if (mem_m.exists(int'(a >> 2))) begin
      chk("rdata", rd_s, mem_m[int'(a >> 2)]);
      chk("rdata_loose", rd_n, mem_m[int'(a >> 2)]);
    end
  endtask

  typedef struct {
    bit          rst;
    bit          we;
    logic [31:0] adr;
    logic [31:0] wd;
    status_t     st;
    status_t     st_ns;
    logic [15:0] wr;
    bit          err;
    bit          rd_chk;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 32'd0,   32'd0, ST_RUN,  ST_RUN,  16'd0, 1'b0, 1'b0, 32'd0};
    tbl[1]  = '{1'b0, 1'b1, 32'd96,  32'd3, ST_RUN,  ST_RUN,  16'd1, 1'b0, 1'b1, 32'd3};
    tbl[2]  = '{1'b0, 1'b1, 32'd100, 32'd7, ST_PASS, ST_PASS, 16'd2, 1'b0, 1'b1, 32'd7};
    tbl[3]  = '{1'b0, 1'b0, 32'd100, 32'd0, ST_PASS, ST_PASS, 16'd2, 1'b0, 1'b1, 32'd7};
    tbl[4]  = '{1'b1, 1'b0, 32'd100, 32'd0, ST_RUN,  ST_RUN,  16'd0, 1'b0, 1'b1, 32'd7};
    tbl[5]  = '{1'b0, 1'b1, 32'd100, 32'd5, ST_FAIL, ST_FAIL, 16'd1, 1'b0, 1'b1, 32'd5};
    tbl[6]  = '{1'b0, 1'b1, 32'd100, 32'd7, ST_FAIL, ST_FAIL, 16'd2, 1'b0, 1'b1, 32'd7};
    tbl[7]  = '{1'b1, 1'b0, 32'd96,  32'd0, ST_RUN,  ST_RUN,  16'd0, 1'b0, 1'b1, 32'd3};
    tbl[8]  = '{1'b0, 1'b1, 32'h104, 32'd1, ST_FAIL, ST_RUN,  16'd0, 1'b1, 1'b1, 32'd0};
    tbl[9]  = '{1'b0, 1'b0, 32'h104, 32'd0, ST_FAIL, ST_RUN,  16'd0, 1'b1, 1'b1, 32'd0};
    tbl[10] = '{1'b0, 1'b0, 32'd98,  32'd0, ST_FAIL, ST_RUN,  16'd0, 1'b1, 1'b1, 32'd0};

    ms = mdl_reset();
    mn = mdl_reset();
    @(negedge clk);

    // Directed table: pass, fail stickiness, reset keeps memory, bad store.
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].rst, tbl[i].we, tbl[i].adr, tbl[i].wd);
      chk("tbl_status", 32'(st_s), 32'(tbl[i].st));
      chk("tbl_status_loose", 32'(st_n), 32'(tbl[i].st_ns));
      chk("tbl_wr_count", 32'(wrc_s), 32'(tbl[i].wr));
      chk("tbl_addr_err", 32'(err_s), 32'(tbl[i].err));
      if (tbl[i].rd_chk) chk("tbl_rdata", rd_s, tbl[i].rd);
    end

    // Watchdog: verdict on the edge that ends cycle 39, count frozen after.
    step(1'b1, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 39; i++) step(1'b0, 1'b0, 32'd0, 32'd0);
    chk("to_pre_status", 32'(st_s), 32'(ST_RUN));
    chk("to_pre_cycle", 32'(cyc_s), 32'd39);
    step(1'b0, 1'b0, 32'd0, 32'd0);
    chk("to_status", 32'(st_s), 32'(ST_TIMEOUT));
    chk("to_done", 32'(done_s), 32'd1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'd0, 32'd0);
    chk("to_frozen", 32'(cyc_s), 32'd39);

    // Mailbox pass in the timeout cycle beats the watchdog.
    step(1'b1, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 39; i++) step(1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b1, 32'd100, 32'd7);
    chk("race_pass", 32'(st_s), 32'(ST_PASS));
    chk("race_pass_loose", 32'(st_n), 32'(ST_PASS));
    chk("race_cycle", 32'(cyc_s), 32'd39);

    // Illegal store in the timeout cycle: FAIL when strict, TIMEOUT when not.
    step(1'b1, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 39; i++) step(1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b1, 32'd8, 32'd1);
    chk("race_fail", 32'(st_s), 32'(ST_FAIL));
    chk("race_timeout_loose", 32'(st_n), 32'(ST_TIMEOUT));

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bit          r, w;
      logic [31:0] a, d;
      r = ($urandom_range(0, 39) == 0);
      w = r ? 1'b0 : ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 5))
        0: a = 32'd96;
        1: a = 32'd100;
        2: a = 32'($urandom_range(0, 63)) << 2;
        3: a = 32'($urandom_range(0, 511));
        4: a = 32'($urandom_range(0, 63)) << 2;
        default: a = $urandom;
      endcase
      d = ($urandom_range(0, 2) == 0) ? 32'd7 : $urandom;
      step(r, w, a, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
